// File: rtl/stage_mem_update_ctrl.sv
// Write-port (port B) sequencer for one lookup-stage table RAM: host updates plus full-table clear sweep.
// Optional write readback check enabled by defining UPD_READBACK_EN.
module stage_mem_update_ctrl #(
    parameter int              STAGE_ID  = 0,
    parameter int              DATA      = 72,
    parameter int              ADDR      = 10,
    parameter logic [DATA-1:0] CLR_VALUE = '0,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [ADDR-1:0]  upd_addr,
    input  logic [DATA-1:0]  upd_data,
    input  logic             clr_start,
    output logic             clr_busy,
    output logic             clr_done,
    output logic             mem_wr,
    output logic [ADDR-1:0]  mem_addr,
    output logic [DATA-1:0]  mem_din,
    input  logic [DATA-1:0]  mem_dout,
    output logic [CNT_W-1:0] wr_count,
    output logic             rb_err
);

    if (STAGE_ID < 0) begin : g_bad_stage
        $error("STAGE_ID must be non-negative");
    end

    typedef enum logic [2:0] {IDLE, CLEAR, WR, RD, CHK} state_t;

    state_t           state, state_nxt;
    logic [ADDR:0]    clr_cnt, clr_cnt_nxt, clr_cnt_inc;
    logic             mem_wr_nxt;
    logic [ADDR-1:0]  mem_addr_nxt;
    logic [DATA-1:0]  mem_din_nxt;
    logic             clr_busy_nxt, clr_done_nxt;
    logic [CNT_W-1:0] wr_count_nxt;
    logic             accept;

    assign upd_ready   = (state == IDLE) && !clr_start && !rst;
    assign accept      = upd_valid && upd_ready;
    // Extra MSB lets the sweep detect completion without the address wrapping to 0.
    assign clr_cnt_inc = clr_cnt + {{ADDR{1'b0}}, 1'b1};

`ifdef UPD_READBACK_EN
    logic rb_err_q, rb_err_nxt;
    assign rb_err = rb_err_q;
`else
    logic unused_dout;
    assign unused_dout = ^mem_dout;
    assign rb_err      = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        clr_cnt_nxt  = clr_cnt;
        mem_wr_nxt   = 1'b0;
        mem_addr_nxt = mem_addr;
        mem_din_nxt  = mem_din;
        clr_busy_nxt = 1'b0;
        clr_done_nxt = 1'b0;
        wr_count_nxt = wr_count;
`ifdef UPD_READBACK_EN
        rb_err_nxt   = rb_err_q;
`endif
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt    = CLEAR;
                    clr_cnt_nxt  = '0;
                    mem_wr_nxt   = 1'b1;
                    mem_addr_nxt = '0;
                    mem_din_nxt  = CLR_VALUE;
                    clr_busy_nxt = 1'b1;
`ifdef UPD_READBACK_EN
                    rb_err_nxt   = 1'b0;
`endif
                end else if (accept) begin
`ifdef UPD_READBACK_EN
                    state_nxt    = WR;
`endif
                    mem_wr_nxt   = 1'b1;
                    mem_addr_nxt = upd_addr;
                    mem_din_nxt  = upd_data;
                    if (wr_count != '1)
                        wr_count_nxt = wr_count + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            CLEAR: begin
                if (clr_cnt_inc[ADDR]) begin
                    state_nxt    = IDLE;
                    clr_done_nxt = 1'b1;
                end else begin
                    clr_cnt_nxt  = clr_cnt_inc;
                    mem_wr_nxt   = 1'b1;
                    mem_addr_nxt = clr_cnt_inc[ADDR-1:0];
                    clr_busy_nxt = 1'b1;
                end
            end
`ifdef UPD_READBACK_EN
            WR: state_nxt = RD;
            RD: state_nxt = CHK;
            CHK: begin
                // mem_din still holds the word just written; dout now reflects the RD-cycle read.
                state_nxt = IDLE;
                if (mem_dout != mem_din)
                    rb_err_nxt = 1'b1;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            wr_count <= '0;
`ifdef UPD_READBACK_EN
            rb_err_q <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            mem_wr   <= mem_wr_nxt;
            mem_addr <= mem_addr_nxt;
            mem_din  <= mem_din_nxt;
            clr_busy <= clr_busy_nxt;
            clr_done <= clr_done_nxt;
            wr_count <= wr_count_nxt;
`ifdef UPD_READBACK_EN
            rb_err_q <= rb_err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_stage_mem_update_ctrl.sv
// Directed bench for stage_mem_update_ctrl: instance a (ADDR=10) for streaming/readback,
// instance b (ADDR=4, CNT_W=2) for clear sweeps, priority, reset abort and counter saturation.
module tb_stage_mem_update_ctrl;

    localparam logic [71:0] CLR_B = 72'h5A_5A00_0000_0000_00A5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_valid, a_ready, a_clr, a_busy, a_done, a_wr, a_rb_err;
    logic [9:0]  a_addr, a_mem_addr;
    logic [71:0] a_data, a_din, a_dout;
    logic [15:0] a_cnt;

    logic        b_valid, b_ready, b_clr, b_busy, b_done, b_wr, b_rb_err;
    logic [3:0]  b_addr, b_mem_addr;
    logic [71:0] b_data, b_din, b_dout;
    logic [1:0]  b_cnt;

    logic        corrupt;
    logic [71:0] ram_a [0:1023];
    logic [71:0] ram_b [0:15];

    int n_chk = 0;
    int n_err = 0;

    stage_mem_update_ctrl #(.STAGE_ID(0), .DATA(72), .ADDR(10), .CLR_VALUE(72'h0), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .upd_valid(a_valid), .upd_ready(a_ready), .upd_addr(a_addr),
        .upd_data(a_data), .clr_start(a_clr), .clr_busy(a_busy), .clr_done(a_done),
        .mem_wr(a_wr), .mem_addr(a_mem_addr), .mem_din(a_din), .mem_dout(a_dout),
        .wr_count(a_cnt), .rb_err(a_rb_err)
    );

    stage_mem_update_ctrl #(.STAGE_ID(1), .DATA(72), .ADDR(4), .CLR_VALUE(CLR_B), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .upd_valid(b_valid), .upd_ready(b_ready), .upd_addr(b_addr),
        .upd_data(b_data), .clr_start(b_clr), .clr_busy(b_busy), .clr_done(b_done),
        .mem_wr(b_wr), .mem_addr(b_mem_addr), .mem_din(b_din), .mem_dout(b_dout),
        .wr_count(b_cnt), .rb_err(b_rb_err)
    );

    // RAM models: registered read, read-before-write; a corrupts address 0x012 on demand.
    always @(posedge clk) begin
        if (a_wr)
            ram_a[a_mem_addr] <= (corrupt && a_mem_addr == 10'h012) ? (a_din ^ 72'h1) : a_din;
        a_dout <= ram_a[a_mem_addr];
    end

    always @(posedge clk) begin
        if (b_wr)
            ram_b[b_mem_addr] <= b_din;
        b_dout <= ram_b[b_mem_addr];
    end

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; corrupt = 1'b0;
        a_valid = 0; a_addr = '0; a_data = '0; a_clr = 0;
        b_valid = 0; b_addr = '0; b_data = '0; b_clr = 0;

        // T1 reset
        repeat (3) tick();
        chk("rst_ready_a", a_ready, 0);
        chk("rst_ready_b", b_ready, 0);
        chk("rst_wr_a", a_wr, 0);
        chk("rst_addr_a", a_mem_addr, 0);
        chk("rst_din_a", a_din, 0);
        chk("rst_busy_b", b_busy, 0);
        chk("rst_done_b", b_done, 0);
        chk("rst_cnt_a", a_cnt, 0);
        chk("rst_rberr_a", a_rb_err, 0);
        chk("rst_rberr_b", b_rb_err, 0);
        rst = 1'b0;
        #1;
        chk("rel_ready_a", a_ready, 1);
        chk("rel_ready_b", b_ready, 1);

`ifndef UPD_READBACK_EN
        // T2 back-to-back updates
        a_valid = 1; a_addr = 10'h005; a_data = 72'hA;
        tick();
        chk("t2_wr0", a_wr, 1);
        chk("t2_addr0", a_mem_addr, 10'h005);
        chk("t2_din0", a_din, 72'hA);
        chk("t2_ready", a_ready, 1);
        a_addr = 10'h3FF; a_data = 72'hB;
        tick();
        chk("t2_wr1", a_wr, 1);
        chk("t2_addr1", a_mem_addr, 10'h3FF);
        chk("t2_din1", a_din, 72'hB);
        a_addr = 10'h000; a_data = 72'hC;
        tick();
        chk("t2_wr2", a_wr, 1);
        chk("t2_addr2", a_mem_addr, 10'h000);
        chk("t2_din2", a_din, 72'hC);
        a_valid = 0;
        tick();
        chk("t2_wr_off", a_wr, 0);
        chk("t2_din_hold", a_din, 72'hC);
        chk("t2_count", a_cnt, 3);
        chk("t2_rberr", a_rb_err, 0);
`endif

        // T3 clear sweep, with a redundant clr_start mid-sweep
        b_clr = 1;
        #1;
        chk("t3_ready_clr", b_ready, 0);
        tick();
        b_clr = 0;
        for (int i = 0; i < 16; i++) begin
            chk("t3_wr", b_wr, 1);
            chk("t3_addr", b_mem_addr, i);
            chk("t3_din", b_din, CLR_B);
            chk("t3_busy", b_busy, 1);
            chk("t3_done_early", b_done, 0);
            chk("t3_ready", b_ready, 0);
            b_clr = (i == 5);
            tick();
        end
        b_clr = 0;
        chk("t3_busy_end", b_busy, 0);
        chk("t3_done", b_done, 1);
        chk("t3_wr_end", b_wr, 0);
        tick();
        chk("t3_done_pulse", b_done, 0);
        chk("t3_wr_idle", b_wr, 0);
        chk("t3_cnt", b_cnt, 0);
        for (int i = 0; i < 16; i++)
            chk("t3_ram", ram_b[i], CLR_B);

        // T4 clr_start beats a same-cycle update
        b_valid = 1; b_addr = 4'h9; b_data = 72'h77; b_clr = 1;
        #1;
        chk("t4_ready", b_ready, 0);
        tick();
        b_clr = 0;
        for (int i = 0; i < 16; i++) begin
            chk("t4_clr_wr", b_wr, 1);
            chk("t4_clr_addr", b_mem_addr, i);
            chk("t4_clr_din", b_din, CLR_B);
            tick();
        end
        chk("t4_done", b_done, 1);
        chk("t4_wr_gap", b_wr, 0);
        chk("t4_ready_after", b_ready, 1);
        tick();
        chk("t4_upd_wr", b_wr, 1);
        chk("t4_upd_addr", b_mem_addr, 4'h9);
        chk("t4_upd_din", b_din, 72'h77);
        chk("t4_cnt", b_cnt, 1);
        b_valid = 0;
        tick();
        chk("t4_wr_off", b_wr, 0);
        chk("t4_ram9", ram_b[9], 72'h77);
        chk("t4_ram8", ram_b[8], CLR_B);
        repeat (4) tick();

        // T5 reset mid-sweep
        b_clr = 1;
        tick();
        b_clr = 0;
        repeat (7) tick();
        chk("t5_addr7", b_mem_addr, 7);
        chk("t5_busy", b_busy, 1);
        rst = 1;
        tick();
        rst = 0;
        chk("t5_wr", b_wr, 0);
        chk("t5_busy_rst", b_busy, 0);
        chk("t5_done_rst", b_done, 0);
        chk("t5_cnt", b_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_done", b_done, 0);
            chk("t5_no_wr", b_wr, 0);
        end

`ifndef UPD_READBACK_EN
        // T7 counter saturation at CNT_W=2
        b_valid = 1;
        for (int i = 0; i < 4; i++) begin
            b_addr = 4'(i); b_data = 72'(i + 1);
            tick();
            chk("t7_wr", b_wr, 1);
        end
        b_valid = 0;
        chk("t7_sat", b_cnt, 3);
        tick();
        chk("t7_hold", b_cnt, 3);
`else
        // T6 readback check
        a_valid = 1; a_addr = 10'h020; a_data = 72'h1234;
        tick();
        a_valid = 0;
        chk("t6_wr_good", a_wr, 1);
        chk("t6_ready_wr", a_ready, 0);
        tick();
        chk("t6_rd_wr", a_wr, 0);
        chk("t6_rd_addr", a_mem_addr, 10'h020);
        chk("t6_ready_rd", a_ready, 0);
        tick();
        chk("t6_ready_chk", a_ready, 0);
        tick();
        chk("t6_good_rberr", a_rb_err, 0);
        chk("t6_ready_idle", a_ready, 1);
        chk("t6_cnt", a_cnt, 1);
        corrupt = 1;
        a_valid = 1; a_addr = 10'h012; a_data = 72'h55AA;
        tick();
        a_valid = 0;
        chk("t6_wr_bad", a_wr, 1);
        tick();
        chk("t6_rberr_n2", a_rb_err, 0);
        tick();
        chk("t6_rberr_n3", a_rb_err, 0);
        tick();
        chk("t6_rberr_set", a_rb_err, 1);
        repeat (5) tick();
        chk("t6_rberr_sticky", a_rb_err, 1);
        a_clr = 1;
        tick();
        a_clr = 0;
        chk("t6_rberr_clr", a_rb_err, 0);
        chk("t6_busy", a_busy, 1);
        begin
            logic seen;
            seen = 0;
            for (int i = 0; i < 1100 && !seen; i++) begin
                if (a_done) seen = 1;
                else tick();
            end
            chk("t6_sweep_done", seen, 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
